// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: ALU-control encodings and default widths.
package mips_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// fwd_mux: priority operand select for one source register (EX/MEM over MEM/WB
// over register file); also reports whether any in-flight writer matches.
module fwd_mux
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] src_addr,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic [DATA_W-1:0] data,
    output logic              match
);

    logic src_nz;
    logic exmem_hit;
    logic memwb_hit;

    // Register 0 is hardwired zero, so it is never a forwarding target.
    assign src_nz    = (src_addr != '0);
    assign exmem_hit = src_nz & exmem_reg_write & (exmem_rd == src_addr);
    assign memwb_hit = src_nz & memwb_reg_write & (memwb_rd == src_addr);
    assign match     = exmem_hit | memwb_hit;

    always_comb begin
        data = reg_data;
        if (exmem_hit)      data = exmem_result;
        else if (memwb_hit) data = memwb_result;
    end

endmodule

// File: rtl/ex_operand_stage.sv
// One-entry EX operand register with forwarding (EX_OPERAND_FORWARD_EN defined)
// or RAW-hazard stall (EX_OPERAND_FORWARD_EN undefined, default build).
module ex_operand_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_rs_data,
    input  logic [DATA_W-1:0] i_rt_data,
    input  logic [DATA_W-1:0] i_imm,
    input  logic [REG_AW-1:0] i_rs_addr,
    input  logic [REG_AW-1:0] i_rt_addr,
    input  logic [REG_AW-1:0] i_rd_addr,
    input  logic [3:0]        i_alu_control,
    input  logic              i_alu_src,
    input  logic              i_reg_write,
    input  logic              i_flush,
    input  logic              i_exmem_reg_write,
    input  logic [REG_AW-1:0] i_exmem_rd,
    input  logic [DATA_W-1:0] i_exmem_result,
    input  logic              i_memwb_reg_write,
    input  logic [REG_AW-1:0] i_memwb_rd,
    input  logic [DATA_W-1:0] i_memwb_result,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_op1,
    output logic [DATA_W-1:0] o_op2,
    output logic [3:0]        o_alu_control,
    output logic [REG_AW-1:0] o_rd_addr,
    output logic              o_reg_write,
    output logic              o_hazard
);

    logic              full;
    logic              full_next;
    logic              capture;
    logic              drain;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs_addr;
    logic [REG_AW-1:0] rt_addr;
    logic [REG_AW-1:0] rd_addr;
    logic [3:0]        alu_control;
    logic              alu_src;
    logic              reg_write;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;
    logic              rs_match;
    logic              rt_match;

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .src_addr        (rs_addr),
        .reg_data        (rs_data),
        .exmem_reg_write (i_exmem_reg_write),
        .exmem_rd        (i_exmem_rd),
        .exmem_result    (i_exmem_result),
        .memwb_reg_write (i_memwb_reg_write),
        .memwb_rd        (i_memwb_rd),
        .memwb_result    (i_memwb_result),
        .data            (rs_fwd),
        .match           (rs_match)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .src_addr        (rt_addr),
        .reg_data        (rt_data),
        .exmem_reg_write (i_exmem_reg_write),
        .exmem_rd        (i_exmem_rd),
        .exmem_result    (i_exmem_result),
        .memwb_reg_write (i_memwb_reg_write),
        .memwb_rd        (i_memwb_rd),
        .memwb_result    (i_memwb_result),
        .data            (rt_fwd),
        .match           (rt_match)
    );

`ifdef EX_OPERAND_FORWARD_EN
    logic unused_match;
    assign unused_match = rs_match ^ rt_match;
    assign o_hazard     = 1'b0;
    assign o_op1        = rs_fwd;
    assign o_op2        = alu_src ? imm : rt_fwd;
`else
    logic unused_fwd;
    assign unused_fwd = ^{rs_fwd, rt_fwd};
    // rt only matters when it actually feeds op2.
    assign o_hazard   = full & (rs_match | (~alu_src & rt_match));
    assign o_op1      = rs_data;
    assign o_op2      = alu_src ? imm : rt_data;
`endif

    assign o_valid       = full & ~o_hazard;
    assign o_ready       = ~full | (o_valid & i_ready);
    assign drain         = o_valid & i_ready;
    assign capture       = i_valid & o_ready & ~i_flush;
    assign o_alu_control = alu_control;
    assign o_rd_addr     = rd_addr;
    assign o_reg_write   = reg_write & full;

    always_comb begin
        full_next = full;
        if (i_flush)      full_next = 1'b0;
        else if (capture) full_next = 1'b1;
        else if (drain)   full_next = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            full        <= 1'b0;
            rs_data     <= '0;
            rt_data     <= '0;
            imm         <= '0;
            rs_addr     <= '0;
            rt_addr     <= '0;
            rd_addr     <= '0;
            alu_control <= '0;
            alu_src     <= 1'b0;
            reg_write   <= 1'b0;
        end else begin
            full <= full_next;
            if (capture) begin
                rs_data     <= i_rs_data;
                rt_data     <= i_rt_data;
                imm         <= i_imm;
                rs_addr     <= i_rs_addr;
                rt_addr     <= i_rt_addr;
                rd_addr     <= i_rd_addr;
                alu_control <= i_alu_control;
                alu_src     <= i_alu_src;
                reg_write   <= i_reg_write;
            end
        end
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage; forwarding checks compile in when
// EX_OPERAND_FORWARD_EN is defined, stall checks otherwise.
module tb_ex_operand_stage;
    import mips_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_rs_data, i_rt_data, i_imm;
    logic [AW-1:0] i_rs_addr, i_rt_addr, i_rd_addr;
    logic [3:0]    i_alu_control;
    logic          i_alu_src, i_reg_write, i_flush;
    logic          i_exmem_reg_write;
    logic [AW-1:0] i_exmem_rd;
    logic [DW-1:0] i_exmem_result;
    logic          i_memwb_reg_write;
    logic [AW-1:0] i_memwb_rd;
    logic [DW-1:0] i_memwb_result;
    logic          i_ready;
    logic          o_valid;
    logic [DW-1:0] o_op1, o_op2;
    logic [3:0]    o_alu_control;
    logic [AW-1:0] o_rd_addr;
    logic          o_reg_write, o_hazard;

    int passed = 0;
    int total  = 0;

    ex_operand_stage #(.DATA_W(DW), .REG_AW(AW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_imm(i_imm),
        .i_rs_addr(i_rs_addr), .i_rt_addr(i_rt_addr), .i_rd_addr(i_rd_addr),
        .i_alu_control(i_alu_control), .i_alu_src(i_alu_src),
        .i_reg_write(i_reg_write), .i_flush(i_flush),
        .i_exmem_reg_write(i_exmem_reg_write), .i_exmem_rd(i_exmem_rd),
        .i_exmem_result(i_exmem_result),
        .i_memwb_reg_write(i_memwb_reg_write), .i_memwb_rd(i_memwb_rd),
        .i_memwb_result(i_memwb_result),
        .i_ready(i_ready), .o_valid(o_valid), .o_op1(o_op1), .o_op2(o_op2),
        .o_alu_control(o_alu_control), .o_rd_addr(o_rd_addr),
        .o_reg_write(o_reg_write), .o_hazard(o_hazard)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic offer(input logic [AW-1:0] rs, input logic [DW-1:0] rsd,
                         input logic [AW-1:0] rt, input logic [DW-1:0] rtd,
                         input logic [AW-1:0] rd, input logic [3:0] ctl,
                         input logic src, input logic [DW-1:0] im);
        i_valid = 1'b1; i_rs_addr = rs; i_rs_data = rsd; i_rt_addr = rt;
        i_rt_data = rtd; i_rd_addr = rd; i_alu_control = ctl; i_alu_src = src;
        i_imm = im; i_reg_write = 1'b1;
    endtask

    initial begin
        i_rst_n = 1'b0; i_valid = 0; i_rs_data = 0; i_rt_data = 0; i_imm = 0;
        i_rs_addr = 0; i_rt_addr = 0; i_rd_addr = 0; i_alu_control = 0;
        i_alu_src = 0; i_reg_write = 0; i_flush = 0;
        i_exmem_reg_write = 0; i_exmem_rd = 0; i_exmem_result = 0;
        i_memwb_reg_write = 0; i_memwb_rd = 0; i_memwb_result = 0; i_ready = 0;

        // reset state
        step(); step();
        chk("rst_valid", o_valid, 0);
        chk("rst_ready", o_ready, 1);
        chk("rst_op1", o_op1, 0);
        chk("rst_op2", o_op2, 0);
        chk("rst_ctl", o_alu_control, 0);
        chk("rst_rd", o_rd_addr, 0);
        chk("rst_rw", o_reg_write, 0);
        chk("rst_hazard", o_hazard, 0);
        i_rst_n = 1'b1;

        // back-to-back ADD then SUB, no bubble
        i_ready = 1'b1;
        offer(5, 32'h10, 6, 32'h20, 8, ALU_ADD, 0, 0);
        step();
        chk("b2b_valid0", o_valid, 1);
        chk("b2b_op1_0", o_op1, 32'h10);
        chk("b2b_op2_0", o_op2, 32'h20);
        chk("b2b_ctl0", o_alu_control, ALU_ADD);
        chk("b2b_rd0", o_rd_addr, 8);
        chk("b2b_ready0", o_ready, 1);
        offer(7, 32'h30, 9, 32'h40, 10, ALU_SUB, 0, 0);
        step();
        chk("b2b_valid1", o_valid, 1);
        chk("b2b_op1_1", o_op1, 32'h30);
        chk("b2b_op2_1", o_op2, 32'h40);
        chk("b2b_ctl1", o_alu_control, ALU_SUB);
        i_valid = 1'b0;
        step();
        chk("drain_valid", o_valid, 0);
        chk("drain_rw", o_reg_write, 0);

        // register 0 is never forwarded / never hazards
        i_ready = 1'b0;
        i_exmem_reg_write = 1; i_exmem_rd = 0; i_exmem_result = 32'hFFFF;
        offer(0, 32'h0, 1, 32'h5, 11, ALU_SLT, 1, 32'h1234);
        step();
        chk("r0_op1", o_op1, 0);
        chk("r0_op2_imm", o_op2, 32'h1234);
        chk("r0_valid", o_valid, 1);
        chk("r0_hazard", o_hazard, 0);
        i_exmem_reg_write = 0;

        // backpressure: new offer must not disturb the held instruction
        offer(2, 32'h99, 3, 32'h98, 12, ALU_AND, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_valid", o_valid, 1);
            chk("bp_ready", o_ready, 0);
            chk("bp_ctl", o_alu_control, ALU_SLT);
            chk("bp_op2", o_op2, 32'h1234);
        end
        i_flush = 1'b1;
        step();
        chk("flush_valid", o_valid, 0);
        chk("flush_rw", o_reg_write, 0);
        i_flush = 1'b0; i_valid = 1'b0;
        step();
        chk("flush_nocap_valid", o_valid, 0);
        chk("flush_nocap_ctl", o_alu_control, ALU_SLT);

`ifdef EX_OPERAND_FORWARD_EN
        offer(3, 32'h1, 4, 32'h2, 13, ALU_OR, 0, 0);
        step();
        i_valid = 1'b0;
        i_exmem_reg_write = 1; i_exmem_rd = 3; i_exmem_result = 32'hAAAA;
        i_memwb_reg_write = 1; i_memwb_rd = 3; i_memwb_result = 32'h5555;
        #1;
        chk("fwd_exmem", o_op1, 32'hAAAA);
        chk("fwd_hazard", o_hazard, 0);
        chk("fwd_valid", o_valid, 1);
        i_exmem_reg_write = 0;
        #1;
        chk("fwd_memwb", o_op1, 32'h5555);
        i_memwb_reg_write = 0;
        #1;
        chk("fwd_none", o_op1, 32'h1);
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
`else
        i_memwb_reg_write = 1; i_memwb_rd = 7; i_memwb_result = 32'h5555;
        offer(4, 32'h44, 7, 32'h77, 14, ALU_NOR, 0, 0);
        step();
        i_valid = 1'b0;
        chk("haz_on", o_hazard, 1);
        chk("haz_valid", o_valid, 0);
        chk("haz_ready", o_ready, 0);
        i_memwb_reg_write = 0;
        #1;
        chk("haz_clear", o_hazard, 0);
        chk("haz_clear_valid", o_valid, 1);
        chk("haz_clear_op2", o_op2, 32'h77);
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        i_memwb_reg_write = 1;
        offer(4, 32'h44, 7, 32'h77, 14, ALU_NOR, 1, 32'h42);
        step();
        i_valid = 1'b0;
        chk("imm_nohaz", o_hazard, 0);
        chk("imm_valid", o_valid, 1);
        chk("imm_op2", o_op2, 32'h42);
        i_memwb_reg_write = 0;
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
`endif

        // asynchronous reset mid-FULL
        offer(4, 32'h44, 5, 32'h55, 15, ALU_ADD, 0, 0);
        step();
        i_valid = 1'b0;
        chk("pre_rst_op1", o_op1, 32'h44);
        chk("pre_rst_rw", o_reg_write, 1);
        #2 i_rst_n = 1'b0;
        #1;
        chk("arst_valid", o_valid, 0);
        chk("arst_op1", o_op1, 0);
        chk("arst_rw", o_reg_write, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        offer(6, 32'h66, 7, 32'h67, 16, ALU_SUB, 0, 0);
        step();
        i_valid = 1'b0;
        chk("post_rst_cap", o_valid, 1);
        chk("post_rst_op1", o_op1, 32'h66);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
